// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: turns the SPI byte stream into CSR commands and shares the
// single CSR port round-robin with one internal hardware requester.
// Reports protocol errors (bad address, overrun, write-data timeout).
`timescale 1ns/1ps
module csr_access_ctrl #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] spi_rx_data,
  input  logic                  spi_rx_valid,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic                  spi_tx_load,
  input  logic                  hw_req,
  input  logic                  hw_we,
  input  logic [ADDR_WIDTH-1:0] hw_addr,
  input  logic [DATA_WIDTH-1:0] hw_wdata,
  output logic                  hw_gnt,
  output logic [DATA_WIDTH-1:0] hw_rdata,
  output logic                  hw_rvalid,
  output logic                  csr_en,
  output logic                  csr_we,
  output logic [ADDR_WIDTH-1:0] csr_addr,
  output logic [DATA_WIDTH-1:0] csr_wdata,
  input  logic [DATA_WIDTH-1:0] csr_rdata,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [1:0] OP_READ     = 2'b01;
  localparam logic [1:0] OP_WRITE    = 2'b10;
  localparam logic [1:0] ERR_BADADDR = 2'b01;
  localparam logic [1:0] ERR_OVERRUN = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_DATA, S_SPI_PEND, S_RD_WAIT} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ptr_hw;     // 1: hardware requester wins a tie
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_load;
  logic                  r_hw_rvalid;
  logic                  r_hw_bad;
  logic                  r_err;
  logic [1:0]            r_err_code;

  logic [1:0]            w_op;
  logic [ADDR_WIDTH-1:0] w_rx_addr;
  logic                  w_rx_addr_ok;
  logic                  w_r_addr_ok;
  logic                  w_hw_addr_ok;
  logic                  w_spi_req;
  logic                  w_hw_req;
  logic                  w_spi_gnt;
  logic                  w_hw_gnt;
  logic                  w_to_err;
  logic                  w_bad_err;
  logic                  w_ovr_err;
  logic [1:0]            w_err_sel;

  assign w_op         = spi_rx_data[DATA_WIDTH-1 -: 2];
  assign w_rx_addr    = spi_rx_data[ADDR_WIDTH-1:0];
  assign w_rx_addr_ok = ({1'b0, w_rx_addr} < DEPTH_L);
  assign w_r_addr_ok  = ({1'b0, r_addr} < DEPTH_L);
  assign w_hw_addr_ok = ({1'b0, hw_addr} < DEPTH_L);

  // Reset suppresses both requests so an abandoned access never reaches the port
  assign w_spi_req = (r_state == S_SPI_PEND) & ~rst;
  assign w_hw_req  = hw_req & ~rst;
  assign w_spi_gnt = w_spi_req & (~w_hw_req | ~r_ptr_hw);
  assign w_hw_gnt  = w_hw_req & (~w_spi_req | r_ptr_hw);

  assign w_to_err  = (r_state == S_WAIT_DATA) & ~spi_rx_valid & (TIMEOUT != 0) & (r_cnt == CNT_LAST);
  assign w_bad_err = spi_rx_valid &
                     (((r_state == S_IDLE) & (w_op == OP_READ) & ~w_rx_addr_ok) |
                      ((r_state == S_WAIT_DATA) & ~w_r_addr_ok));
  assign w_ovr_err = spi_rx_valid & ((r_state == S_SPI_PEND) | (r_state == S_RD_WAIT));

  // Error code selection with timeout > bad address > overrun precedence
  always_comb begin
    w_err_sel = ERR_OVERRUN;
    if (w_to_err)       w_err_sel = ERR_TIMEOUT;
    else if (w_bad_err) w_err_sel = ERR_BADADDR;
  end

  // CSR port driven by the winning requester; all zero when nobody is granted
  always_comb begin
    csr_en    = 1'b0;
    csr_we    = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    if (w_spi_gnt) begin
      csr_en    = 1'b1;
      csr_we    = r_we;
      csr_addr  = r_addr;
      csr_wdata = r_we ? r_wdata : '0;
    end else if (w_hw_gnt && w_hw_addr_ok) begin
      csr_en    = 1'b1;
      csr_we    = hw_we;
      csr_addr  = hw_addr;
      csr_wdata = hw_we ? hw_wdata : '0;
    end
  end

  // Command address/op and write data capture (data path, no reset needed)
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && spi_rx_valid) begin
      r_addr <= w_rx_addr;
      r_we   <= (w_op == OP_WRITE);
    end
    if (r_state == S_WAIT_DATA && spi_rx_valid) r_wdata <= spi_rx_data;
  end

  // SPI command FSM, arbitration pointer, response and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_ptr_hw    <= 1'b0;
      r_tx_data   <= '0;
      r_tx_load   <= 1'b0;
      r_hw_rvalid <= 1'b0;
      r_hw_bad    <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_tx_load <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (spi_rx_valid) begin
            if (w_op == OP_READ) begin
              if (w_rx_addr_ok) begin
                r_state <= S_SPI_PEND;
              end else begin
                r_tx_data <= '1;
                r_tx_load <= 1'b1;
              end
            end else if (w_op == OP_WRITE) begin
              r_cnt   <= '0;
              r_state <= S_WAIT_DATA;
            end
          end
        end
        S_WAIT_DATA: begin
          if (spi_rx_valid)  r_state <= w_r_addr_ok ? S_SPI_PEND : S_IDLE;
          else if (w_to_err) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt + 1'b1;
        end
        S_SPI_PEND: begin
          if (w_spi_gnt) r_state <= r_we ? S_IDLE : S_RD_WAIT;
        end
        S_RD_WAIT: begin
          r_tx_data <= csr_rdata;
          r_tx_load <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_spi_gnt)     r_ptr_hw <= 1'b1;
      else if (w_hw_gnt) r_ptr_hw <= 1'b0;
      r_hw_rvalid <= w_hw_gnt & ~hw_we;
      r_hw_bad    <= w_hw_gnt & ~w_hw_addr_ok;
      r_err       <= w_to_err | w_bad_err | w_ovr_err;
      if (w_to_err | w_bad_err | w_ovr_err) r_err_code <= w_err_sel;
    end
  end

  assign spi_tx_data = r_tx_data;
  assign spi_tx_load = r_tx_load;
  assign hw_gnt      = w_hw_gnt;
  assign hw_rvalid   = r_hw_rvalid;
  assign hw_rdata    = r_hw_bad ? '1 : csr_rdata;
  assign busy        = (r_state != S_IDLE);
  assign err         = r_err;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: a register-file model answers CSR accesses,
// a negedge monitor logs port activity into queues that each test compares
// against expectations it pushed when driving the stimulus.
`timescale 1ns/1ps
module tb_csr_access_ctrl;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] spi_rx_data = '0;
  logic spi_rx_valid = 1'b0;
  logic [DW-1:0] spi_tx_data;
  logic spi_tx_load;
  logic hw_req = 1'b0;
  logic hw_we = 1'b0;
  logic [AW-1:0] hw_addr = '0;
  logic [DW-1:0] hw_wdata = '0;
  logic hw_gnt;
  logic [DW-1:0] hw_rdata;
  logic hw_rvalid;
  logic csr_en, csr_we;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_wdata;
  logic [DW-1:0] csr_rdata;
  logic busy, err;
  logic [1:0] err_code;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_strobe = 0;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; int c; } acc_t;
  typedef struct { logic [DW-1:0] d; int c; } tx_t;
  acc_t act_wr[$];
  acc_t exp_wr[$];
  acc_t act_rd[$];
  tx_t  act_tx[$];
  tx_t  exp_tx[$];

  csr_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
    .spi_tx_data(spi_tx_data), .spi_tx_load(spi_tx_load),
    .hw_req(hw_req), .hw_we(hw_we), .hw_addr(hw_addr), .hw_wdata(hw_wdata),
    .hw_gnt(hw_gnt), .hw_rdata(hw_rdata), .hw_rvalid(hw_rvalid),
    .csr_en(csr_en), .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .busy(busy), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port register file: read data valid the cycle after the access
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) begin
    if (csr_en && csr_we) mem[csr_addr] <= csr_wdata;
    if (csr_en && !csr_we) csr_rdata <= mem[csr_addr];
  end

  // Port monitor
  always @(negedge clk) begin
    if (csr_en === 1'b1 && csr_we === 1'b1) act_wr.push_back('{a: csr_addr, d: csr_wdata, c: cyc});
    if (csr_en === 1'b1 && csr_we === 1'b0) act_rd.push_back('{a: csr_addr, d: 8'h00, c: cyc});
    if (spi_tx_load === 1'b1) act_tx.push_back('{d: spi_tx_data, c: cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    spi_rx_data = b; spi_rx_valid = 1'b1; last_strobe = cyc;
    tick();
    spi_rx_valid = 1'b0; spi_rx_data = '0;
  endtask

  task automatic wait_wr(input int n);
    for (int k = 0; k < 20 && act_wr.size() < n; k++) @(negedge clk);
  endtask

  task automatic wait_tx(input int n);
    for (int k = 0; k < 20 && act_tx.size() < n; k++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, spi_tx_load, err, hw_rvalid, csr_en, hw_gnt} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000", {busy, spi_tx_load, err, hw_rvalid, csr_en, hw_gnt});
    end
    total++;
    if ({err_code, spi_tx_data} !== 10'h0) begin
      bad++; $display("FAIL reset_data: got %h want 000", {err_code, spi_tx_data});
    end
    act_wr.delete(); act_rd.delete(); act_tx.delete();
  endtask

  task automatic test_spi_write();
    acc_t e, g;
    tick();
    send_byte(8'h80);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL wr_busy_wait: got %b want 1", busy); end
    send_byte(8'h0C);
    exp_wr.push_back('{a: 6'd0, d: 8'h0C, c: last_strobe + 1});
    wait_wr(1);
    total++;
    if (act_wr.size() == 0) begin
      bad++; $display("FAIL wr_spi: got no write want addr 00 data 0c");
      exp_wr.delete();
    end else begin
      e = exp_wr.pop_front(); g = act_wr.pop_front();
      if (g.a !== e.a || g.d !== e.d || g.c !== e.c) begin
        bad++; $display("FAIL wr_spi: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", g.a, g.d, g.c, e.a, e.d, e.c);
      end
    end
    tick(); tick();
    @(negedge clk);
    total++;
    if (act_wr.size() != 0 || busy !== 1'b0) begin
      bad++; $display("FAIL wr_single_idle: got writes=%0d busy=%b want 0 0", act_wr.size(), busy);
    end
  endtask

  task automatic test_read_path();
    acc_t e, g, r;
    tx_t te, tg;
    tick();
    hw_req = 1'b1; hw_we = 1'b1; hw_addr = 6'd27; hw_wdata = 8'hA5;
    exp_wr.push_back('{a: 6'd27, d: 8'hA5, c: cyc});
    @(negedge clk);
    total++;
    if (hw_gnt !== 1'b1) begin bad++; $display("FAIL hw_wr_gnt: got %b want 1", hw_gnt); end
    tick();
    hw_req = 1'b0; hw_we = 1'b0;
    wait_wr(1);
    total++;
    if (act_wr.size() == 0) begin
      bad++; $display("FAIL hw_wr: got no write want addr 1b data a5"); exp_wr.delete();
    end else begin
      e = exp_wr.pop_front(); g = act_wr.pop_front();
      if (g.a !== e.a || g.d !== e.d || g.c !== e.c) begin
        bad++; $display("FAIL hw_wr: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", g.a, g.d, g.c, e.a, e.d, e.c);
      end
    end
    tick();
    act_rd.delete();
    send_byte(8'h5B);
    exp_tx.push_back('{d: 8'hA5, c: last_strobe + 3});
    wait_tx(1);
    total++;
    if (act_rd.size() == 0) begin
      bad++; $display("FAIL rd_csr_access: got none want addr 1b at cycle %0d", last_strobe + 1);
    end else begin
      r = act_rd.pop_front();
      if (r.a !== 6'd27 || r.c !== last_strobe + 1) begin
        bad++; $display("FAIL rd_csr_access: got a=%h c=%0d want a=1b c=%0d", r.a, r.c, last_strobe + 1);
      end
    end
    total++;
    if (act_tx.size() == 0) begin
      bad++; $display("FAIL rd_tx: got no load want a5"); exp_tx.delete();
    end else begin
      te = exp_tx.pop_front(); tg = act_tx.pop_front();
      if (tg.d !== te.d || tg.c !== te.c) begin
        bad++; $display("FAIL rd_tx: got d=%h c=%0d want d=%h c=%0d", tg.d, tg.c, te.d, te.c);
      end
    end
  endtask

  task automatic test_arbitration();
    acc_t e, g;
    // Pointer favours HW here: the last grant went to the SPI read
    tick();
    send_byte(8'h81); send_byte(8'h33);
    hw_req = 1'b1; hw_we = 1'b1; hw_addr = 6'd2; hw_wdata = 8'h44;
    exp_wr.push_back('{a: 6'd2, d: 8'h44, c: cyc});
    exp_wr.push_back('{a: 6'd1, d: 8'h33, c: cyc + 1});
    @(negedge clk);
    total++;
    if (hw_gnt !== 1'b1) begin bad++; $display("FAIL arb_hw_first: got hw_gnt=%b want 1", hw_gnt); end
    tick();
    hw_req = 1'b0; hw_we = 1'b0;
    wait_wr(2);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (act_wr.size() == 0) begin
        bad++; $display("FAIL arb_hw_order%0d: got no write", i);
      end else begin
        e = exp_wr.pop_front(); g = act_wr.pop_front();
        if (g.a !== e.a || g.d !== e.d || g.c !== e.c) begin
          bad++; $display("FAIL arb_hw_order%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i, g.a, g.d, g.c, e.a, e.d, e.c);
        end
      end
    end
    exp_wr.delete();
    // Lone HW read: moves the pointer to SPI and exercises hw_rvalid
    tick();
    hw_req = 1'b1; hw_we = 1'b0; hw_addr = 6'd2;
    tick();
    hw_req = 1'b0;
    @(negedge clk);
    total++;
    if (hw_rvalid !== 1'b1 || hw_rdata !== 8'h44) begin
      bad++; $display("FAIL hw_rd: got rvalid=%b rdata=%h want 1 44", hw_rvalid, hw_rdata);
    end
    tick();
    send_byte(8'h82); send_byte(8'h66);
    hw_req = 1'b1; hw_we = 1'b1; hw_addr = 6'd3; hw_wdata = 8'h77;
    exp_wr.push_back('{a: 6'd2, d: 8'h66, c: cyc});
    exp_wr.push_back('{a: 6'd3, d: 8'h77, c: cyc + 1});
    @(negedge clk);
    total++;
    if (hw_gnt !== 1'b0) begin bad++; $display("FAIL arb_spi_first: got hw_gnt=%b want 0", hw_gnt); end
    tick();
    @(negedge clk);
    total++;
    if (hw_gnt !== 1'b1) begin bad++; $display("FAIL arb_hw_next: got hw_gnt=%b want 1", hw_gnt); end
    tick();
    hw_req = 1'b0; hw_we = 1'b0;
    wait_wr(2);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (act_wr.size() == 0) begin
        bad++; $display("FAIL arb_spi_order%0d: got no write", i);
      end else begin
        e = exp_wr.pop_front(); g = act_wr.pop_front();
        if (g.a !== e.a || g.d !== e.d || g.c !== e.c) begin
          bad++; $display("FAIL arb_spi_order%0d: got a=%h d=%h c=%0d want a=%h d=%h c=%0d", i, g.a, g.d, g.c, e.a, e.d, e.c);
        end
      end
    end
    exp_wr.delete();
  endtask

  task automatic test_nop();
    tick();
    send_byte(8'hC5);
    @(negedge clk);
    total++;
    if ({busy, err} !== 2'b00) begin bad++; $display("FAIL nop_reserved: got busy,err=%b want 00", {busy, err}); end
    send_byte(8'h3F);
    @(negedge clk);
    total++;
    if ({busy, err} !== 2'b00) begin bad++; $display("FAIL nop_plain: got busy,err=%b want 00", {busy, err}); end
  endtask

  task automatic test_bad_addr();
    tx_t te, tg;
    tick();
    act_rd.delete(); act_wr.delete(); act_tx.delete();
    send_byte(8'h60);
    exp_tx.push_back('{d: 8'hFF, c: last_strobe + 1});
    @(negedge clk);
    total++;
    if ({err, err_code, csr_en, busy} !== 5'b10100) begin
      bad++; $display("FAIL bad_rd_err: got err,code,en,busy=%b want 10100", {err, err_code, csr_en, busy});
    end
    wait_tx(1);
    total++;
    if (act_tx.size() == 0) begin
      bad++; $display("FAIL bad_rd_tx: got no load want ff"); exp_tx.delete();
    end else begin
      te = exp_tx.pop_front(); tg = act_tx.pop_front();
      if (tg.d !== te.d || tg.c !== te.c) begin
        bad++; $display("FAIL bad_rd_tx: got d=%h c=%0d want d=%h c=%0d", tg.d, tg.c, te.d, te.c);
      end
    end
    total++;
    if (act_rd.size() != 0) begin bad++; $display("FAIL bad_rd_noaccess: got %0d reads want 0", act_rd.size()); end
    tick();
    send_byte(8'hA0); send_byte(8'h11);
    @(negedge clk);
    total++;
    if ({err, err_code, busy} !== 4'b1010) begin
      bad++; $display("FAIL bad_wr_err: got err,code,busy=%b want 1010", {err, err_code, busy});
    end
    tick(); tick();
    hw_req = 1'b1; hw_we = 1'b0; hw_addr = 6'd40;
    @(negedge clk);
    total++;
    if ({hw_gnt, csr_en} !== 2'b10) begin bad++; $display("FAIL hw_bad_gnt: got gnt,en=%b want 10", {hw_gnt, csr_en}); end
    tick();
    hw_req = 1'b0;
    @(negedge clk);
    total++;
    if (hw_rvalid !== 1'b1 || hw_rdata !== 8'hFF) begin
      bad++; $display("FAIL hw_bad_rd: got rvalid=%b rdata=%h want 1 ff", hw_rvalid, hw_rdata);
    end
    total++;
    if (act_wr.size() != 0 || act_rd.size() != 0) begin
      bad++; $display("FAIL bad_noaccess: got wr=%0d rd=%0d want 0 0", act_wr.size(), act_rd.size());
    end
  endtask

  task automatic test_timeout();
    tick();
    act_wr.delete();
    send_byte(8'h83);
    tick(); tick(); tick();
    @(negedge clk);
    total++;
    if ({busy, err} !== 2'b10) begin bad++; $display("FAIL to_early: got busy,err=%b want 10 at cycle %0d", {busy, err}, cyc); end
    tick();
    @(negedge clk);
    total++;
    if ({err, err_code, busy} !== 4'b1110) begin
      bad++; $display("FAIL to_err: got err,code,busy=%b want 1110", {err, err_code, busy});
    end
    tick(); tick();
    total++;
    if (act_wr.size() != 0) begin bad++; $display("FAIL to_nowrite: got %0d writes want 0", act_wr.size()); end
  endtask

  task automatic test_overrun();
    tx_t te, tg;
    tick();
    act_tx.delete();
    send_byte(8'h5B);
    exp_tx.push_back('{d: 8'hA5, c: last_strobe + 3});
    tick();
    send_byte(8'h00);
    @(negedge clk);
    total++;
    if ({err, err_code, busy} !== 4'b1100) begin
      bad++; $display("FAIL ovr_err: got err,code,busy=%b want 1100", {err, err_code, busy});
    end
    wait_tx(1);
    total++;
    if (act_tx.size() == 0) begin
      bad++; $display("FAIL ovr_tx: got no load want a5"); exp_tx.delete();
    end else begin
      te = exp_tx.pop_front(); tg = act_tx.pop_front();
      if (tg.d !== te.d || tg.c !== te.c) begin
        bad++; $display("FAIL ovr_tx: got d=%h c=%0d want d=%h c=%0d", tg.d, tg.c, te.d, te.c);
      end
    end
    tick();
    @(negedge clk);
    total++;
    if ({err, err_code} !== 3'b010) begin bad++; $display("FAIL ovr_hold: got err,code=%b want 010", {err, err_code}); end
  endtask

  task automatic test_reset_mid();
    tick();
    act_wr.delete();
    send_byte(8'h84);
    rst = 1'b1; tick(); rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, err, err_code, spi_tx_load, spi_tx_data} !== 13'h0) begin
      bad++; $display("FAIL rst_wait: got %h want 0000", {busy, err, err_code, spi_tx_load, spi_tx_data});
    end
    tick();
    send_byte(8'h85); send_byte(8'h99);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (csr_en !== 1'b0) begin bad++; $display("FAIL rst_pend_en: got %b want 0", csr_en); end
    tick(); rst = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, err, err_code} !== 4'b0000) begin bad++; $display("FAIL rst_pend_idle: got %b want 0000", {busy, err, err_code}); end
    tick(); tick(); tick();
    total++;
    if (act_wr.size() != 0) begin bad++; $display("FAIL rst_nowrite: got %0d writes want 0", act_wr.size()); end
  endtask

  initial begin
    test_reset();
    test_spi_write();
    test_read_path();
    test_arbitration();
    test_nop();
    test_bad_addr();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequences and arbitrates all accesses to the single-port CSR register file.
- Parses the SPI byte stream into CSR commands. Command byte is {op[1:0], addr[5:0]}; a write command is followed by one data byte.
- Shares the CSR port round-robin with one internal hardware requester (PWM/GPIO status updates).
- Returns read data to the SPI block and flags protocol errors.

Parameters:
- ADDR_WIDTH, 6, command-byte address field width.
- DATA_WIDTH, 8, CSR word and SPI byte width.
- DEPTH, 32, number of implemented CSRs; addresses >= DEPTH are invalid.
- TIMEOUT, 255, max cycles to wait for a write data byte; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- spi_rx_data  in  DATA_WIDTH  byte from SPI block
- spi_rx_valid  in  1  one-cycle strobe, spi_rx_data valid
- spi_tx_data  out  DATA_WIDTH  read response byte
- spi_tx_load  out  1  one-cycle strobe, spi_tx_data valid
- hw_req  in  1  internal access request, held until granted
- hw_we  in  1  1 = write, 0 = read
- hw_addr  in  ADDR_WIDTH  internal address
- hw_wdata  in  DATA_WIDTH  internal write data
- hw_gnt  out  1  combinational grant; the access executes this cycle
- hw_rdata  out  DATA_WIDTH  read data (= csr_rdata)
- hw_rvalid  out  1  high the cycle after a granted hw read
- csr_en  out  1  CSR port enable (combinational)
- csr_we  out  1  CSR write enable
- csr_addr  out  ADDR_WIDTH  CSR address
- csr_wdata  out  DATA_WIDTH  CSR write data
- csr_rdata  in  DATA_WIDTH  CSR read data, valid the cycle after csr_en & !csr_we
- busy  out  1  SPI FSM not in IDLE
- err  out  1  one-cycle error strobe
- err_code  out  2  01 bad address, 10 overrun, 11 timeout; holds last code

Behaviour:
- Reset values: state IDLE; spi_tx_data 0; spi_tx_load, hw_rvalid, err 0; err_code 00; priority pointer = SPI; timeout counter 0. Reset mid-transaction abandons any pending access with no CSR write.
- Op decode: 00 NOP; 01 READ; 10 WRITE; 11 reserved, treated as NOP with no error.
- FSM state IDLE, on spi_rx_valid:
  - READ -> SPI_PEND.
  - WRITE -> WAIT_DATA.
  - NOP or reserved -> stay in IDLE.
- FSM state WAIT_DATA:
  - spi_rx_valid: latch the data byte -> SPI_PEND (write).
  - Counter reaches TIMEOUT cycles with no byte -> IDLE, err with code 11.
- FSM state SPI_PEND: requests the CSR port. On grant, a write -> IDLE; a read -> RD_WAIT.
- FSM state RD_WAIT (one cycle): register csr_rdata into spi_tx_data, pulse spi_tx_load -> IDLE.
- Read timing: command strobe at T -> grant at T+1 at the earliest -> spi_tx_load at T+3.
- Bad address (addr >= DEPTH), read: no CSR access; spi_tx_data = all ones; spi_tx_load and err (code 01) pulse the cycle after the command strobe.
- Bad address, write: the data byte is consumed and discarded; err (code 01) the cycle after the data strobe.
- Overrun: spi_rx_valid while in SPI_PEND or RD_WAIT drops the byte and pulses err (code 10); the FSM is unaffected.
- Arbitration, one access per cycle:
  - If only one requester is active, it is granted immediately.
  - If both are active, the requester not granted last wins; the priority pointer updates on every grant.
  - Starvation bound: each requester waits at most 1 cycle.
- Internal address check: hw_addr >= DEPTH is granted but does not assert csr_en; hw_rvalid still pulses with hw_rdata = all ones.
- Port outputs: csr_* are combinational from the winning requester; they are 0 when there is no grant.
- err precedence (same cycle): timeout > bad address > overrun; only one err pulse per cycle.

Test Plan:
- SPI write 0x80 (op 10, addr 0) then byte 0x0C, no hw_req -> one cycle with csr_en=1, csr_we=1, csr_addr=0, csr_wdata=0x0C; busy returns to 0.
- Preload CSR[27]=0xA5, send 0x5B (READ addr 27) at cycle T -> csr read at T+1; spi_tx_data=0xA5 and spi_tx_load=1 at T+3.
- hw_req held continuously with SPI_PEND active at the same cycle; priority pointer = SPI -> SPI granted first, hw_gnt next cycle; repeat with pointer = HW -> HW granted first.
- Send 0x60 (READ addr 32) -> no csr_en; spi_tx_data=0xFF with spi_tx_load, err=1, err_code=01.
- TIMEOUT=4: send 0x83, no data byte -> err code 11 after 4 cycles in WAIT_DATA, FSM IDLE, no CSR write. Extra byte during RD_WAIT -> err code 10.
- Assert rst in WAIT_DATA and in SPI_PEND -> next cycle IDLE, all outputs at reset values, no csr_we observed.
